// File: rtl/draw_seq_pkg.sv
// Shared types for draw_sequencer: FSM state encoding and its width.
package draw_seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    ARM,
    DRAW,
    HOLD
  } draw_state_e;

endpackage

// File: rtl/layer_next_sel.sv
// layer_next_sel: finds the lowest requesting layer strictly above cur.
module layer_next_sel #(
  parameter int NUM_LAYERS = 2,
  parameter int LIDX_W     = $clog2(NUM_LAYERS)
) (
  input  logic [NUM_LAYERS-1:0] layer_req,
  input  logic [LIDX_W-1:0]     cur,
  output logic                  found,
  output logic [LIDX_W-1:0]     next_idx
);

  // Scan downwards so the last hit written is the lowest qualifying index.
  always_comb begin
    found    = 1'b0;
    next_idx = '0;
    for (int unsigned j = NUM_LAYERS; j > 0; j--) begin
      if (layer_req[j-1] && ((j - 1) > 32'(cur))) begin
        found    = 1'b1;
        next_idx = LIDX_W'(j - 1);
      end
    end
  end

endmodule

// File: rtl/draw_sequencer.sv
// draw_sequencer: per-frame sequencing of a base picture layer plus overlays.
// Optional draw watchdog is compiled in with `define DRAW_SEQ_TIMEOUT_EN.
module draw_sequencer
  import draw_seq_pkg::*;
#(
  parameter int NUM_LAYERS  = 2,
  parameter int MODE_W      = 3,
  parameter int LIDX_W      = $clog2(NUM_LAYERS),
  parameter int FCNT_W      = 8,
  parameter int TIMEOUT_CYC = 1048575
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_LAYERS-1:0] layer_req,
  input  logic [NUM_LAYERS-1:0] layer_done,
  input  logic                  frame_tick,
  input  logic                  sync_tick,
  input  logic [MODE_W-1:0]     pic_size,
  output logic [NUM_LAYERS-1:0] layer_start,
  output logic [LIDX_W-1:0]     active_layer,
  output logic [MODE_W-1:0]     mode_start,
  output logic                  busy,
  output logic [FCNT_W-1:0]     frame_count,
  output logic                  overrun,
  output logic                  timeout_err
);

  if (NUM_LAYERS < 2 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("draw_sequencer: NUM_LAYERS must be >= 2 and TIMEOUT_CYC >= 1");
  end

  draw_state_e       state;
  logic [LIDX_W-1:0] cur;
  logic [MODE_W-1:0] mode_q;
  logic              tick_pending;
  logic              tick;
  logic              to_hit;
  logic              draw_end;
  logic              next_found;
  logic [LIDX_W-1:0] next_idx;

  assign tick     = frame_tick | sync_tick;
  assign draw_end = (state == DRAW) && (layer_done[cur] || to_hit);

  layer_next_sel #(
    .NUM_LAYERS(NUM_LAYERS),
    .LIDX_W    (LIDX_W)
  ) u_next_sel (
    .layer_req(layer_req),
    .cur      (cur),
    .found    (next_found),
    .next_idx (next_idx)
  );

`ifdef DRAW_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt;

  assign to_hit = (state == DRAW) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              to_cnt <= '0;
    else if (state == DRAW) to_cnt <= to_cnt + 1'b1;
    else                    to_cnt <= '0;
  end
`else
  assign to_hit = 1'b0;
`endif

  // Outputs are registered views of the current state, so they lag it by one
  // cycle; this gives the two-cycle done/tick-to-start latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cur          <= '0;
      mode_q       <= '0;
      tick_pending <= 1'b0;
      layer_start  <= '0;
      active_layer <= '0;
      mode_start   <= '0;
      busy         <= 1'b0;
      frame_count  <= '0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      layer_start  <= (state == ARM) ? (NUM_LAYERS'(1) << cur) : '0;
      active_layer <= cur;
      mode_start   <= (state == DRAW && cur == '0) ? mode_q : '0;
      busy         <= (state == ARM) || (state == DRAW);
      overrun      <= 1'b0;
      timeout_err  <= to_hit && !layer_done[cur];

      if ((state == ARM || state == DRAW) && tick) begin
        overrun      <= tick_pending;
        tick_pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          cur   <= '0;
          state <= ARM;
        end
        ARM: begin
          if (cur == '0) mode_q <= pic_size;
          state <= DRAW;
        end
        DRAW: begin
          if (draw_end) begin
            if (next_found) begin
              cur   <= next_idx;
              state <= ARM;
            end else begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (tick_pending || tick) begin
            cur          <= '0;
            frame_count  <= frame_count + 1'b1;
            tick_pending <= 1'b0;
            state        <= ARM;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed self-checking bench for draw_sequencer with four layers.
module tb_draw_sequencer;

  logic       clk;
  logic       reset;
  logic [3:0] layer_req;
  logic [3:0] layer_done;
  logic       frame_tick;
  logic       sync_tick;
  logic [2:0] pic_size;
  logic [3:0] layer_start;
  logic [1:0] active_layer;
  logic [2:0] mode_start;
  logic       busy;
  logic [7:0] frame_count;
  logic       overrun;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;
  int ovr_seen = 0;
  int to_seen = 0;

  draw_sequencer #(
    .NUM_LAYERS (4),
    .MODE_W     (3),
    .FCNT_W     (8),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .layer_req   (layer_req),
    .layer_done  (layer_done),
    .frame_tick  (frame_tick),
    .sync_tick   (sync_tick),
    .pic_size    (pic_size),
    .layer_start (layer_start),
    .active_layer(active_layer),
    .mode_start  (mode_start),
    .busy        (busy),
    .frame_count (frame_count),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (overrun === 1'b1)     ovr_seen++;
    if (timeout_err === 1'b1) to_seen++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Done one cycle after the start is seen; returns layer_start two cycles after done.
  task automatic finish_layer(input int l, output logic [3:0] nxt);
    step();
    layer_done = 4'(1 << l);
    step();
    layer_done = '0;
    step();
    nxt = layer_start;
  endtask

  task automatic test_reset();
    reset = 1'b1; layer_req = '0; layer_done = '0;
    frame_tick = 1'b0; sync_tick = 1'b0; pic_size = 3'd3;
    step(); step();
    checks++;
    if ({layer_start, active_layer, mode_start, busy, frame_count, overrun, timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_values: got ls=%b al=%0d ms=%0d busy=%b fc=%0d ov=%b to=%b want all 0",
               layer_start, active_layer, mode_start, busy, frame_count, overrun, timeout_err);
    end
    reset = 1'b0;
    step();
    checks++;
    if (layer_start !== 4'b0000) begin
      errors++; $display("FAIL reset_cycle1_start: got %b want 0000", layer_start);
    end
    step();
    checks++;
    if (layer_start !== 4'b0001 || busy !== 1'b1) begin
      errors++; $display("FAIL reset_cycle2_start: got ls=%b busy=%b want ls=0001 busy=1", layer_start, busy);
    end
    step();
    checks++;
    if (mode_start !== 3'd3 || layer_start !== 4'b0000) begin
      errors++; $display("FAIL base_mode_start: got ms=%0d ls=%b want ms=3 ls=0000", mode_start, layer_start);
    end
    layer_done = 4'b0001;
    step();
    layer_done = '0;
    checks++;
    if (mode_start !== 3'd3) begin
      errors++; $display("FAIL mode_after_done: got %0d want 3", mode_start);
    end
    step();
    checks++;
    if (busy !== 1'b0 || mode_start !== 3'd0) begin
      errors++; $display("FAIL hold_idle_outputs: got busy=%b ms=%0d want busy=0 ms=0", busy, mode_start);
    end
    step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    checks++;
    if (frame_count !== 8'd1) begin
      errors++; $display("FAIL frame_count_first: got %0d want 1", frame_count);
    end
    step();
    checks++;
    if (layer_start !== 4'b0001) begin
      errors++; $display("FAIL tick_to_start: got %b want 0001", layer_start);
    end
  endtask

  task automatic test_order();
    logic [3:0] nxt;
    layer_req = 4'b1010;
    finish_layer(0, nxt);
    checks++;
    if (nxt !== 4'b0010 || active_layer !== 2'd1) begin
      errors++; $display("FAIL order_layer1: got ls=%b al=%0d want ls=0010 al=1", nxt, active_layer);
    end
    step();
    layer_done = 4'b0100;
    step();
    layer_done = '0;
    step();
    checks++;
    if (layer_start !== 4'b0000 || busy !== 1'b1) begin
      errors++; $display("FAIL foreign_done_ignored: got ls=%b busy=%b want ls=0000 busy=1", layer_start, busy);
    end
    finish_layer(1, nxt);
    checks++;
    if (nxt !== 4'b1000 || active_layer !== 2'd3) begin
      errors++; $display("FAIL order_layer3: got ls=%b al=%0d want ls=1000 al=3", nxt, active_layer);
    end
    finish_layer(3, nxt);
    checks++;
    if (nxt !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL order_hold: got ls=%b busy=%b want ls=0000 busy=0", nxt, busy);
    end
  endtask

  task automatic test_sync_pending();
    logic [3:0] nxt;
    int ov0;
    ov0 = ovr_seen;
    layer_req = 4'b0010;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    checks++;
    if (layer_start !== 4'b0001 || frame_count !== 8'd2) begin
      errors++; $display("FAIL sync_frame2_start: got ls=%b fc=%0d want ls=0001 fc=2", layer_start, frame_count);
    end
    finish_layer(0, nxt);
    step();
    sync_tick = 1'b1;
    step();
    sync_tick = 1'b0;
    finish_layer(1, nxt);
    checks++;
    if (nxt !== 4'b0000 || frame_count !== 8'd3) begin
      errors++; $display("FAIL sync_pending_exit: got ls=%b fc=%0d want ls=0000 fc=3", nxt, frame_count);
    end
    step();
    checks++;
    if (layer_start !== 4'b0001) begin
      errors++; $display("FAIL sync_pending_restart: got %b want 0001", layer_start);
    end
    checks++;
    if (ovr_seen !== ov0) begin
      errors++; $display("FAIL sync_no_overrun: got %0d pulses want 0", ovr_seen - ov0);
    end
  endtask

  task automatic test_overrun();
    logic [3:0] nxt;
    int ov0;
    ov0 = ovr_seen;
    step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    sync_tick = 1'b1;
    step();
    sync_tick = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_pulse: got %b want 1", overrun);
    end
    step();
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL overrun_one_cycle: got %b want 0", overrun);
    end
    layer_req = 4'b0000;
    finish_layer(0, nxt);
    checks++;
    if (nxt !== 4'b0000 || frame_count !== 8'd4) begin
      errors++; $display("FAIL overrun_restart_fc: got ls=%b fc=%0d want ls=0000 fc=4", nxt, frame_count);
    end
    step();
    checks++;
    if (layer_start !== 4'b0001) begin
      errors++; $display("FAIL overrun_restart: got %b want 0001", layer_start);
    end
    finish_layer(0, nxt);
    step(); step(); step();
    checks++;
    if (layer_start !== 4'b0000 || frame_count !== 8'd4 || busy !== 1'b0) begin
      errors++; $display("FAIL overrun_single_pending: got ls=%b fc=%0d busy=%b want ls=0000 fc=4 busy=0",
                         layer_start, frame_count, busy);
    end
    checks++;
    if (ovr_seen - ov0 !== 1) begin
      errors++; $display("FAIL overrun_count: got %0d pulses want 1", ovr_seen - ov0);
    end
  endtask

  task automatic test_pic_zero();
    logic [3:0] nxt;
    pic_size = 3'd0;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    checks++;
    if (layer_start !== 4'b0001 || frame_count !== 8'd5) begin
      errors++; $display("FAIL pic0_start: got ls=%b fc=%0d want ls=0001 fc=5", layer_start, frame_count);
    end
    step();
    checks++;
    if (mode_start !== 3'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL pic0_mode: got ms=%0d busy=%b want ms=0 busy=1", mode_start, busy);
    end
    finish_layer(0, nxt);
  endtask

  task automatic test_wrap();
    logic [3:0] nxt;
    pic_size = 3'd2;
    for (int i = 0; i < 250; i++) begin
      sync_tick = 1'b1;
      step();
      sync_tick = 1'b0;
      step();
      finish_layer(0, nxt);
    end
    checks++;
    if (frame_count !== 8'd255) begin
      errors++; $display("FAIL wrap_allones: got %0d want 255", frame_count);
    end
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    checks++;
    if (frame_count !== 8'd0) begin
      errors++; $display("FAIL wrap_zero: got %0d want 0", frame_count);
    end
    step();
    finish_layer(0, nxt);
  endtask

  task automatic test_reset_mid_draw();
    pic_size = 3'd5;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    step();
    checks++;
    if (mode_start !== 3'd5 || busy !== 1'b1 || frame_count !== 8'd1) begin
      errors++; $display("FAIL pre_abort_state: got ms=%0d busy=%b fc=%0d want ms=5 busy=1 fc=1",
                         mode_start, busy, frame_count);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({layer_start, active_layer, mode_start, busy, frame_count, overrun, timeout_err} !== '0) begin
      errors++;
      $display("FAIL abort_immediate: got ls=%b al=%0d ms=%0d busy=%b fc=%0d ov=%b to=%b want all 0",
               layer_start, active_layer, mode_start, busy, frame_count, overrun, timeout_err);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (layer_start !== 4'b0000 || busy !== 1'b0) begin
        errors++; $display("FAIL start_in_reset: got ls=%b busy=%b want 0000/0", layer_start, busy);
      end
    end
    reset = 1'b0;
    step();
    step();
    checks++;
    if (layer_start !== 4'b0001) begin
      errors++; $display("FAIL restart_after_abort: got %b want 0001", layer_start);
    end
  endtask

  task automatic test_watchdog();
    int to0;
    to0 = to_seen;
`ifdef DRAW_SEQ_TIMEOUT_EN
    for (int c = 1; c <= 15; c++) begin
      step();
      checks++;
      if (timeout_err !== 1'b0) begin
        errors++; $display("FAIL timeout_early: cycle %0d got %b want 0", c, timeout_err);
      end
    end
    step();
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++; $display("FAIL timeout_pulse: got %b want 1", timeout_err);
    end
    step();
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b0 || layer_start !== 4'b0000) begin
      errors++; $display("FAIL timeout_advance: got to=%b busy=%b ls=%b want 0/0/0000", timeout_err, busy, layer_start);
    end
    checks++;
    if (to_seen - to0 !== 1) begin
      errors++; $display("FAIL timeout_count: got %0d pulses want 1", to_seen - to0);
    end
`else
    for (int c = 0; c < 24; c++) step();
    checks++;
    if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL draw_waits: got busy=%b to=%b want busy=1 to=0", busy, timeout_err);
    end
    checks++;
    if (to_seen !== to0) begin
      errors++; $display("FAIL timeout_disabled: got %0d pulses want 0", to_seen - to0);
    end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL sim_time_limit: run exceeded time bound");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_order();
    test_sync_pending();
    test_overrun();
    test_pic_zero();
    test_wrap();
    test_reset_mid_draw();
    test_watchdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/draw_sequencer.md
# draw_sequencer

Parametrised successor to the two-state picture/cursor draw controller. Sequences up to `NUM_LAYERS` draw engines (layer 0 = base picture, higher indices = overlays such as cursor or text). Each frame it starts the base layer, then every requesting overlay in ascending index order, then holds until a refresh tick. Refresh ticks that arrive mid-frame are remembered rather than dropped, and each base-layer pass carries a captured mode word. Sits between the tick generators and the per-layer draw engines.

## Interface
- `NUM_LAYERS`, default 2: number of draw layers; must be at least 2.
- `MODE_W`, default 3: width of the picture mode/size word.
- `LIDX_W`, default `$clog2(NUM_LAYERS)`: layer index width (derived; not overridden).
- `FCNT_W`, default 8: frame counter width.
- `TIMEOUT_CYC`, default 1048575: draw watchdog limit in cycles; used only with `DRAW_SEQ_TIMEOUT_EN`.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `layer_req`  in  `NUM_LAYERS`  per-layer redraw request, level, sampled at selection; bit 0 ignored.
- `layer_done`  in  `NUM_LAYERS`  per-layer completion pulse.
- `frame_tick`  in  1  slow refresh tick, 1-cycle pulse.
- `sync_tick`  in  1  fast sync tick, 1-cycle pulse.
- `pic_size`  in  `MODE_W`  base picture mode; 0 = no picture.
- `layer_start`  out  `NUM_LAYERS`  one-hot start pulse.
- `active_layer`  out  `LIDX_W`  index of the current layer.
- `mode_start`  out  `MODE_W`  captured mode during a base-layer draw, else 0.
- `busy`  out  1  high in ARM or DRAW.
- `frame_count`  out  `FCNT_W`  completed frames; wraps.
- `overrun`  out  1  1-cycle pulse when a tick is lost.
- `timeout_err`  out  1  1-cycle pulse on watchdog expiry; tied 0 when the watchdog is compiled out.

## Operation
- States: IDLE, ARM, DRAW, HOLD.
- IDLE → ARM unconditionally, with `cur` = 0.
- ARM lasts exactly one cycle.
  - `layer_start[cur]` = 1.
  - Captures `pic_size` into `mode_q` when `cur` = 0.
  - Goes to DRAW.
- DRAW waits for `layer_done[cur]`. Other `layer_done` bits are ignored.
- On done, select the lowest `j` > `cur` with `layer_req[j]` = 1 (sampled that cycle):
  - if such a `j` exists, go to ARM with `cur` = `j`;
  - otherwise go to HOLD.
- HOLD waits for `tick_pending` or `frame_tick|sync_tick`. Then it goes to ARM with `cur` = 0, increments `frame_count`, and clears `tick_pending`.
- `tick_pending` is set by `frame_tick|sync_tick` in ARM or DRAW.
  - If a tick arrives while `tick_pending` is already 1, pulse `overrun`; `tick_pending` stays 1.
  - A tick in the same cycle as the HOLD exit is consumed by that exit; no overrun.
- `mode_start` = `mode_q` while in DRAW with `cur` = 0, else 0. When `pic_size` = 0 the base layer still runs, with `mode_start` = 0.
- `busy` = (state is ARM or DRAW).
- `frame_count` is `FCNT_W`-bit unsigned and wraps from all-ones to 0.
- Reset mid-frame aborts immediately; no `layer_start` is issued while reset is high.

## Timing
- All outputs are registered.
- Reset values: `layer_start` = 0, `active_layer` = 0, `mode_start` = 0, `busy` = 0, `frame_count` = 0, `overrun` = 0, `timeout_err` = 0; internal state = IDLE.
- First `layer_start[0]` appears 2 cycles after reset deasserts.
- Done-to-next-start latency: done in cycle `n` gives `layer_start` in cycle `n`+2.
- Tick-to-start latency from HOLD: tick in cycle `n` gives `layer_start[0]` in cycle `n`+2.
- A `layer_done` during ARM is ignored. Engines must assert done no earlier than the cycle after start.
- `mode_start` is valid from the cycle after `layer_start[0]` until the cycle after done.

## Configuration
- `DRAW_SEQ_TIMEOUT_EN` defined:
  - a cycle counter runs while in DRAW;
  - on reaching `TIMEOUT_CYC` with no done, pulse `timeout_err` and advance exactly as if done had arrived.
- Undefined: no counter; DRAW waits indefinitely; `timeout_err` = 0.

## Structure
- Package `draw_seq_pkg` holds the state enum (IDLE/ARM/DRAW/HOLD) and the state-width constant.
- Sub-module `layer_next_sel`: combinational selector of the next requesting layer above `cur`. Outputs a found flag and an index.

## Test plan
- Reset release with `NUM_LAYERS`=4, `pic_size`=3, `layer_req`=0 → `layer_start`=0001 at cycle 2; `mode_start`=3 from cycle 3; done → HOLD; `frame_tick` → restart with `frame_count`=1.
- `layer_req`=1010, done on each layer → start order 0, 1, 3; layer 2 skipped; HOLD after layer 3.
- `sync_tick` during a layer-1 DRAW → after layer-1 done, ARM layer 0 next without waiting; `frame_count` increments.
- Two ticks during one DRAW → `overrun` pulses once; only one pending restart.
- `pic_size`=0 → base layer still started; `mode_start` stays 0.
- With `DRAW_SEQ_TIMEOUT_EN`, `TIMEOUT_CYC`=16, no done → `timeout_err` pulse after 16 DRAW cycles, then advance; reset mid-DRAW → all outputs 0 immediately.
